// File: rtl/midi_msg_decoder.sv
// MIDI byte-stream decoder: tracks running status and emits one registered
// strobe per complete Note On/Off; other traffic is filtered, aborts are counted.
`timescale 1ns/1ps
module midi_msg_decoder #(
  parameter int BYTE_TIMEOUT = 2_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic [7:0] midi_velocity_out,
  output logic [7:0] midi_received_note_out,
  output logic [3:0] midi_channel_out,
  output logic       midi_status_out,
  output logic       midi_data_ready_out,
  output logic [7:0] drop_count_out
);

  localparam int CNT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_D1, ST_WAIT_D2} state_t;
  typedef enum logic [1:0] {RS_NONE, RS_NOTE, RS_OTHER, RS_SYSEX} rs_kind_t;

  state_t     state_q, state_d;
  rs_kind_t   rs_kind_q, rs_kind_d;
  logic       rs_on_q, rs_on_d;
  logic [3:0] rs_ch_q, rs_ch_d;
  logic [7:0] note_q, note_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] vel_out_q, vel_out_d;
  logic [7:0] note_out_q, note_out_d;
  logic [3:0] ch_out_q, ch_out_d;
  logic       status_out_q, status_out_d;
  logic       ready_q, ready_d;
  logic [7:0] drop_q, drop_d;
  logic       drop_inc;

  logic is_rt, is_status, is_data;
  assign is_rt     = byte_valid_in && (byte_in >= 8'hF8);
  assign is_status = byte_valid_in && byte_in[7] && !is_rt;
  assign is_data   = byte_valid_in && !byte_in[7];

  always_comb begin
    state_d      = state_q;
    rs_kind_d    = rs_kind_q;
    rs_on_d      = rs_on_q;
    rs_ch_d      = rs_ch_q;
    note_d       = note_q;
    cnt_d        = cnt_q;
    vel_out_d    = vel_out_q;
    note_out_d   = note_out_q;
    ch_out_d     = ch_out_q;
    status_out_d = status_out_q;
    ready_d      = 1'b0;
    drop_inc     = 1'b0;
    drop_d       = drop_q;

    if (is_status) begin
      drop_inc = (state_q == ST_WAIT_D2);
      cnt_d    = '0;
      if (byte_in[7:5] == 3'b100) begin
        rs_kind_d = RS_NOTE;
        rs_on_d   = byte_in[4];
        rs_ch_d   = byte_in[3:0];
        state_d   = ST_WAIT_D1;
      end else if (byte_in < 8'hF0) begin
        rs_kind_d = RS_OTHER;
        state_d   = ST_IDLE;
      end else if (byte_in == 8'hF0) begin
        rs_kind_d = RS_SYSEX;
        state_d   = ST_IDLE;
      end else begin
        rs_kind_d = RS_NONE;
        state_d   = ST_IDLE;
      end
    end else if (is_data) begin
      case (state_q)
        ST_IDLE: drop_inc = (rs_kind_q == RS_NONE);
        ST_WAIT_D1: begin
          note_d  = byte_in;
          state_d = ST_WAIT_D2;
          cnt_d   = '0;
        end
        ST_WAIT_D2: begin
          vel_out_d    = byte_in;
          note_out_d   = note_q;
          ch_out_d     = rs_ch_q;
          status_out_d = rs_on_q && (byte_in != 8'h00);
          ready_d      = 1'b1;
          state_d      = ST_WAIT_D1;
          cnt_d        = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (!byte_valid_in && state_q == ST_WAIT_D2) begin
      // Real-time bytes fall through here untouched, so they freeze the timer.
      if (cnt_q == CNT_LAST) begin
        state_d  = ST_WAIT_D1;
        cnt_d    = '0;
        drop_inc = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      rs_kind_q    <= RS_NONE;
      rs_on_q      <= 1'b0;
      rs_ch_q      <= 4'h0;
      note_q       <= 8'h00;
      cnt_q        <= '0;
      vel_out_q    <= 8'h00;
      note_out_q   <= 8'h00;
      ch_out_q     <= 4'h0;
      status_out_q <= 1'b0;
      ready_q      <= 1'b0;
      drop_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      rs_kind_q    <= rs_kind_d;
      rs_on_q      <= rs_on_d;
      rs_ch_q      <= rs_ch_d;
      note_q       <= note_d;
      cnt_q        <= cnt_d;
      vel_out_q    <= vel_out_d;
      note_out_q   <= note_out_d;
      ch_out_q     <= ch_out_d;
      status_out_q <= status_out_d;
      ready_q      <= ready_d;
      drop_q       <= drop_d;
    end
  end

  assign midi_velocity_out      = vel_out_q;
  assign midi_received_note_out = note_out_q;
  assign midi_channel_out       = ch_out_q;
  assign midi_status_out        = status_out_q;
  assign midi_data_ready_out    = ready_q;
  assign drop_count_out         = drop_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Bench for midi_msg_decoder: directed and random byte streams against a
// message-level reference model; events are compared with their cycle stamp.
`timescale 1ns/1ps
module tb_midi_msg_decoder;
  localparam int TO = 100;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid_in = 1'b0;
  logic [7:0] midi_velocity_out, midi_received_note_out, drop_count_out;
  logic [3:0] midi_channel_out;
  logic       midi_status_out, midi_data_ready_out;

  midi_msg_decoder #(.BYTE_TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .midi_velocity_out(midi_velocity_out), .midi_received_note_out(midi_received_note_out),
    .midi_channel_out(midi_channel_out), .midi_status_out(midi_status_out),
    .midi_data_ready_out(midi_data_ready_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  // event = {cycle, status, channel, note, velocity}
  logic [52:0] exp_q[$];
  logic [52:0] obs_q[$];

  // reference model: kind 0=none 1=note 2=other 3=sysex
  int         m_kind;
  bit         m_on;
  logic [3:0] m_ch;
  bit         m_have_note;
  logic [7:0] m_note;
  int         m_idle;
  int         m_drop;

  function automatic void model_reset();
    m_kind = 0; m_on = 0; m_ch = 4'h0; m_have_note = 0; m_note = 8'h00; m_idle = 0; m_drop = 0;
  endfunction

  function automatic void bump();
    if (m_drop < 255) m_drop = m_drop + 1;
  endfunction

  function automatic void model_byte(bit v, logic [7:0] b);
    if (!v) begin
      if (m_kind == 1 && m_have_note) begin
        m_idle++;
        if (m_idle == TO) begin m_have_note = 0; m_idle = 0; bump(); end
      end
    end else if (b >= 8'hF8) begin
      // real-time: nothing at all
    end else if (b >= 8'h80) begin
      if (m_kind == 1 && m_have_note) bump();
      m_have_note = 0; m_idle = 0;
      if (b < 8'hA0) begin m_kind = 1; m_on = b[4]; m_ch = b[3:0]; end
      else if (b < 8'hF0) m_kind = 2;
      else if (b == 8'hF0) m_kind = 3;
      else m_kind = 0;
    end else if (m_kind == 1) begin
      if (!m_have_note) begin m_note = b; m_have_note = 1; m_idle = 0; end
      else begin
        exp_q.push_back({32'(cyc), (m_on && b != 8'h00), m_ch, m_note, b});
        m_have_note = 0; m_idle = 0;
      end
    end else if (m_kind == 0) bump();
  endfunction

  always @(posedge clk_in) if (!rst_in) begin
    cyc++;
    model_byte(byte_valid_in, byte_in);
  end

  always @(negedge clk_in) if (midi_data_ready_out)
    obs_q.push_back({32'(cyc), midi_status_out, midi_channel_out, midi_received_note_out, midi_velocity_out});

  task automatic send(input logic [7:0] b);
    @(negedge clk_in); byte_in = b; byte_valid_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk_in); byte_valid_in = 1'b0; end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({midi_velocity_out, midi_received_note_out, midi_channel_out, midi_status_out,
         midi_data_ready_out, drop_count_out} !== 37'd0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    model_reset();
    @(negedge clk_in); rst_in = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    send(8'h90); send(8'h3C); send(8'h64); idle(3);
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++; $display("FAIL basic_count: got %0d events, required 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL basic_event: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    n_cmp++;
    if ({midi_status_out, midi_channel_out, midi_received_note_out, midi_velocity_out} !== {1'b1, 4'h0, 8'h3C, 8'h64}) begin
      n_bad++; $display("FAIL basic_hold: got %b %h %h %h required 1 0 3c 64", midi_status_out,
                        midi_channel_out, midi_received_note_out, midi_velocity_out);
    end
    n_cmp++;
    if (drop_count_out !== 8'd0) begin
      n_bad++; $display("FAIL basic_drop: got %0d required 0", drop_count_out);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_running();
    send(8'h93); send(8'h40); send(8'h50); send(8'h41); send(8'h00); idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 2) begin
      n_bad++; $display("FAIL running_count: got %0d events, required 2", obs_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL running_event%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (midi_status_out !== 1'b0 || midi_velocity_out !== 8'h00) begin
      n_bad++; $display("FAIL running_vel0_off: got status %b vel %h required 0 00", midi_status_out, midi_velocity_out);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_realtime();
    send(8'h80); send(8'h3C); send(8'hF8); send(8'h20); idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1) begin
      n_bad++; $display("FAIL realtime_count: got %0d events, required 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL realtime_event: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_abort();
    send(8'h90); send(8'h3C); send(8'h85); send(8'h30); send(8'h10); idle(3);
    n_cmp++;
    if (drop_count_out !== 8'd1) begin
      n_bad++; $display("FAIL abort_drop: got %0d required 1", drop_count_out);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1) begin
      n_bad++; $display("FAIL abort_count: got %0d events, required 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL abort_event: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    send(8'h90); send(8'h3C); idle(150);
    n_cmp++;
    if (drop_count_out !== 8'd2 || obs_q.size() != 0) begin
      n_bad++; $display("FAIL timeout_drop: got %0d drops %0d events required 2 drops 0 events", drop_count_out, obs_q.size());
    end
    send(8'h40); send(8'h7F); idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1) begin
      n_bad++; $display("FAIL timeout_count: got %0d events, required 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL timeout_event: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout_edge();
    // data byte on the 100th idle-counting slot must still complete the message
    send(8'h91); send(8'h22); idle(TO - 1); send(8'h33); idle(3);
    n_cmp++;
    if (obs_q.size() != 1 || drop_count_out !== 8'd2) begin
      n_bad++; $display("FAIL edge_data_wins: got %0d events %0d drops required 1 events 2 drops", obs_q.size(), drop_count_out);
    end
    send(8'h44); idle(TO); idle(2);
    n_cmp++;
    if (drop_count_out !== 8'd3) begin
      n_bad++; $display("FAIL edge_expire: got %0d required 3", drop_count_out);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size() || (exp_q.size() == 1 && obs_q[0] !== exp_q[0])) begin
      n_bad++; $display("FAIL edge_events: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    send(8'h95);
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom_range(0, 127))); send(8'($urandom_range(0, 127)));
    end
    idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 10) begin
      n_bad++; $display("FAIL b2b_count: got %0d events, required 10", obs_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL b2b_event%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      int k = $urandom_range(0, 15);
      if (k < 8) send(8'($urandom_range(0, 127)));
      else if (k < 11) send(8'($urandom_range(8'h80, 8'h9F)));
      else if (k == 11) send(8'($urandom_range(8'hA0, 8'hF7)));
      else if (k == 12) send(8'($urandom_range(8'hF8, 8'hFF)));
      else if (k == 13) idle($urandom_range(90, 110));
      else idle($urandom_range(1, 3));
    end
    idle(3);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL random_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL random_event%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (drop_count_out !== 8'(m_drop)) begin
      n_bad++; $display("FAIL random_drop: got %0d required %0d", drop_count_out, m_drop);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_no_status_reset();
    @(negedge clk_in); byte_valid_in = 1'b0; rst_in = 1'b1; model_reset();
    @(negedge clk_in); rst_in = 1'b0;
    send(8'h3C); send(8'h64); idle(2);
    n_cmp++;
    if (drop_count_out !== 8'd2 || obs_q.size() != 0) begin
      n_bad++; $display("FAIL nostatus_drop: got %0d drops %0d events required 2 drops 0 events", drop_count_out, obs_q.size());
    end
    send(8'hC0); send(8'h05); idle(2);
    n_cmp++;
    if (drop_count_out !== 8'd2 || obs_q.size() != 0) begin
      n_bad++; $display("FAIL other_silent: got %0d drops %0d events required 2 drops 0 events", drop_count_out, obs_q.size());
    end
    send(8'h90); send(8'h3C);
    @(posedge clk_in); #2;
    rst_in = 1'b1; byte_valid_in = 1'b0; model_reset();
    #1;
    n_cmp++;
    if ({midi_velocity_out, midi_received_note_out, midi_channel_out, midi_status_out,
         midi_data_ready_out, drop_count_out} !== 37'd0) begin
      n_bad++; $display("FAIL async_reset: got drop %0d note %h required all 0", drop_count_out, midi_received_note_out);
    end
    @(negedge clk_in); rst_in = 1'b0;
    send(8'h64); idle(3);
    n_cmp++;
    if (drop_count_out !== 8'd1 || obs_q.size() != 0) begin
      n_bad++; $display("FAIL post_reset: got %0d drops %0d events required 1 drops 0 events", drop_count_out, obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturate();
    send(8'hF1);
    for (int i = 0; i < 300; i++) send(8'h01);
    idle(2);
    n_cmp++;
    if (drop_count_out !== 8'd255 || m_drop != 255) begin
      n_bad++; $display("FAIL saturate: got %0d required 255", drop_count_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_running();
    test_realtime();
    test_abort();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_random();
    test_no_status_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/midi_msg_decoder.md
# midi_msg_decoder

Byte-level MIDI message decoder that sits between the UART receiver and `midi_burst`. It consumes raw received bytes and tracks MIDI running status. For every complete Note On / Note Off message it emits one decoded event on the exact signal set `midi_burst` consumes: velocity, note, channel, status and a one-cycle data-ready strobe. All other MIDI traffic is filtered out, and abandoned or malformed messages are counted.

## Interface
Parameters:
- `BYTE_TIMEOUT`, default 2_000_000: clock cycles allowed between data byte 1 and data byte 2 before the partial message is abandoned.

Ports:
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset. One clock; reset is asynchronous and active-high.
- `byte_in` input 8: received byte from the UART.
- `byte_valid_in` input 1: `byte_in` is valid. Every high cycle counts as one byte.
- `midi_velocity_out` output 8: velocity of the last event.
- `midi_received_note_out` output 8: note number of the last event.
- `midi_channel_out` output 4: channel of the last event.
- `midi_status_out` output 1: 1 = note on, 0 = note off.
- `midi_data_ready_out` output 1: one-cycle strobe. The other outputs are valid on this cycle.
- `drop_count_out` output 8: saturating count of discarded bytes or messages.

## Operation
Byte classes:
- Data byte: bit7 = 0.
- Status byte: 0x80–0xF7.
- Real-time byte: 0xF8–0xFF.

Running-status kind (`rs_kind`) is one of NONE, NOTE, OTHER or SYSEX. Stored alongside it are `rs_on` (1 = note on) and `rs_ch`.

Message states are IDLE, WAIT_D1 and WAIT_D2.
- **Real-time byte:** ignored entirely. No change to state, counters or timeout. Allowed between any two bytes.
- **0x80–0x9F:** sets `rs_kind`=NOTE, `rs_on`=`byte[4]`, `rs_ch`=`byte[3:0]`, then goes to WAIT_D1.
- **0xA0–0xEF:** sets `rs_kind`=OTHER, then goes to IDLE.
- **0xF0:** sets `rs_kind`=SYSEX, then goes to IDLE.
- **0xF1–0xF7:** sets `rs_kind`=NONE, then goes to IDLE.
- **Status byte while in WAIT_D2:** first abandon the partial message (`drop_count` +1), then apply the status rule above.
- **Data byte in IDLE:**
  - `rs_kind`=NONE: drop it, `drop_count` +1.
  - OTHER or SYSEX: discard silently, no count.
- **Data byte in WAIT_D1:** latch the note, go to WAIT_D2, clear the timeout counter.
- **Data byte in WAIT_D2:** latch the velocity and emit an event, then return to WAIT_D1 so running status applies to the next data byte.
  - Event status = `rs_on` AND (velocity ≠ 0), so note-on with velocity 0 is emitted as note off with velocity 0x00.
- **Timeout:** the counter runs only in WAIT_D2 and increments every cycle without a data byte.
  - On reaching `BYTE_TIMEOUT`: return to WAIT_D1, `drop_count` +1, clear the counter.
  - Running status is retained.
- **Width rules:**
  - Timeout counter is `$clog2(BYTE_TIMEOUT+1)` bits.
  - `drop_count_out` saturates at 255 and never wraps.
  - Multiple drop causes in one cycle are impossible, since there is one byte per cycle.

## Timing
- Reset, applied asynchronously:
  - all outputs 0, including `drop_count_out`=0;
  - state IDLE, `rs_kind`=NONE;
  - timeout counter 0.
- Reset mid-message discards the partial message and does not count it. Outputs go to 0 without waiting for a clock edge.
- Latency: `midi_data_ready_out` is high exactly on the cycle after the clock edge that samples the second data byte. All outputs are registered.
- `midi_data_ready_out` is high for exactly 1 cycle per event. Back-to-back bytes on consecutive cycles are supported, with no backpressure.
- Between strobes, velocity, note, channel and status hold their last event values.
- `drop_count_out` updates 1 cycle after the offending byte or the timeout cycle.
- If a timeout expires on the same cycle a data byte arrives, the data byte wins: it completes the message, and there is no drop.

## Test plan
- **Basic note on:** bytes 0x90, 0x3C, 0x64 → one strobe with `status`=1, `ch`=0, `note`=0x3C, `vel`=0x64, one cycle after the 0x64 sample; `drop_count`=0.
- **Running status and velocity-0 off:** bytes 0x93, 0x40, 0x50, 0x41, 0x00 → two strobes:
  - (1, ch 3, 0x40, 0x50);
  - then (0, ch 3, 0x41, 0x00).
- **Real-time interleave:** bytes 0x80, 0x3C, 0xF8, 0x20, sent back-to-back → one strobe (0, ch 0, 0x3C, 0x20); no strobe or state change on 0xF8.
- **Abort on new status:** bytes 0x90, 0x3C, 0x85, 0x30, 0x10 → `drop_count`=1, then one strobe (0, ch 5, 0x30, 0x10).
- **Timeout:** with `BYTE_TIMEOUT`=100, send 0x90, 0x3C, wait 150 idle cycles, then send 0x40, 0x7F → `drop_count`=1, then strobe (1, ch 0, 0x40, 0x7F).
- **No status and async reset:**
  - After reset, send 0x3C, 0x64 → no strobe, `drop_count`=2.
  - Then 0xC0, 0x05 → no strobe, `drop_count` stays 2.
  - Then 0x90, 0x3C and assert `rst_in` between clock edges → all outputs 0 immediately.
  - After release, 0x64 → no strobe, `drop_count`=1.
